pixel_layer_arbiter: RTL and testbench

//  Per-pixel arbiter between N sprite/ball hit generators and the colour mapper. Picks one winning object per pixel
//  (fixed priority) and emits its configured layer code on is_ball. Code table is written by software at any time
//  and committed only at frame start (tear-free). Pipelined, 2-pixel latency, with per-frame collision flags.

---
 rtl/pixel_layer_arbiter_pkg.sv | 27 ++
 rtl/pixel_layer_arbiter_if.sv | 34 +++
 rtl/pixel_layer_arbiter_prio_enc.sv | 21 ++
 rtl/pixel_layer_arbiter.sv | 105 ++++++++++
 tb/tb_pixel_layer_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_layer_arbiter_pkg.sv
// Shared types and constants for the pixel layer arbiter: object config record,
// layer code type and the reset-default code table.
package vga_layer_pkg;

  localparam int unsigned N_OBJ   = 4;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned IDX_W   = $clog2(N_OBJ);

  typedef logic [CODE_W-1:0] layer_code_t;

  localparam layer_code_t CODE_BG = '0;

  typedef struct packed {
    layer_code_t code;
    logic        en;
  } obj_cfg_t;

  // Reset default: object i draws with code i+1 and is enabled.
  function automatic obj_cfg_t code_for(input int unsigned i);
    obj_cfg_t c;
    c.code = layer_code_t'(i + 1);
    c.en   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pixel_layer_arbiter_if.sv
// Pixel stream, frame strobe, config write and arbiter result signals bundled
// between the upstream hit generators/software (master) and the arbiter (slave).
interface pixel_layer_arbiter_if;
  import vga_layer_pkg::*;

  logic                pixel_en;
  logic                vsync_pulse;
  logic [COORD_W-1:0]  DrawX;
  logic [COORD_W-1:0]  DrawY;
  logic [N_OBJ-1:0]    obj_hit;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [IDX_W-1:0]    cfg_idx;
  layer_code_t         cfg_code;
  logic                cfg_en;
  layer_code_t         is_ball;
  logic [COORD_W-1:0]  DrawX_o;
  logic [COORD_W-1:0]  DrawY_o;
  logic [N_OBJ-1:0]    collision;
  logic                collision_valid;

  modport master (
    output pixel_en, vsync_pulse, DrawX, DrawY, obj_hit,
    output cfg_valid, cfg_idx, cfg_code, cfg_en,
    input  cfg_ready, is_ball, DrawX_o, DrawY_o, collision, collision_valid
  );

  modport slave (
    input  pixel_en, vsync_pulse, DrawX, DrawY, obj_hit,
    input  cfg_valid, cfg_idx, cfg_code, cfg_en,
    output cfg_ready, is_ball, DrawX_o, DrawY_o, collision, collision_valid
  );

endinterface

// File: rtl/pixel_layer_arbiter_prio_enc.sv
// Combinational fixed-priority encoder: reports whether any request is set and
// the index of the lowest set request bit.
module prio_enc_n #(
  parameter int unsigned N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  output logic         o_any,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/pixel_layer_arbiter.sv
// Per-pixel fixed-priority arbiter over N object hits with a tear-free code table
// (shadow committed at frame start), 2-pixel pipeline and per-frame collision flags.
module pixel_layer_arbiter
  import vga_layer_pkg::*;
(
  input logic                   Clk,
  input logic                   Reset,
  pixel_layer_arbiter_if.slave  bus
);

  obj_cfg_t            r_shadow [N_OBJ];
  obj_cfg_t            r_active [N_OBJ];
  logic [N_OBJ-1:0]    r_hit_m;
  logic [COORD_W-1:0]  r_x1, r_y1;
  layer_code_t         r_is_ball;
  logic [COORD_W-1:0]  r_x_o, r_y_o;
  logic [N_OBJ-1:0]    r_acc;
  logic [N_OBJ-1:0]    r_coll;
  logic                r_coll_valid;

  logic [N_OBJ-1:0]    w_en_mask;
  logic                w_any;
  logic [IDX_W-1:0]    w_win;
  layer_code_t         w_code;
  logic [N_OBJ-1:0]    w_contrib;
  logic                w_cfg_wr;

  always_comb begin
    w_en_mask = '0;
    for (int i = 0; i < int'(N_OBJ); i++) w_en_mask[i] = r_active[i].en;
  end

  prio_enc_n #(
    .N (N_OBJ)
  ) u_prio_enc (
    .i_req (r_hit_m),
    .o_any (w_any),
    .o_idx (w_win)
  );

  always_comb begin
    w_code    = w_any ? r_active[w_win].code : CODE_BG;
    w_contrib = (bus.pixel_en && ($countones(r_hit_m) > 1)) ? r_hit_m : '0;
    // Writes are blocked during the commit cycle so commit never races a write.
    w_cfg_wr  = bus.cfg_valid && !bus.vsync_pulse && (32'(bus.cfg_idx) < N_OBJ);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(N_OBJ); i++) begin
        r_shadow[i] <= code_for(i);
        r_active[i] <= code_for(i);
      end
    end else begin
      for (int i = 0; i < int'(N_OBJ); i++) begin
        if (w_cfg_wr && (bus.cfg_idx == IDX_W'(i))) begin
          r_shadow[i] <= '{code: bus.cfg_code, en: bus.cfg_en};
        end
        if (bus.vsync_pulse) r_active[i] <= r_shadow[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hit_m   <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_is_ball <= CODE_BG;
      r_x_o     <= '0;
      r_y_o     <= '0;
    end else if (bus.pixel_en) begin
      r_hit_m   <= bus.obj_hit & w_en_mask;
      r_x1      <= bus.DrawX;
      r_y1      <= bus.DrawY;
      r_is_ball <= w_code;
      r_x_o     <= r_x1;
      r_y_o     <= r_y1;
    end
  end

  // The S2 contribution in the vsync cycle still belongs to the closing frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc        <= '0;
      r_coll       <= '0;
      r_coll_valid <= 1'b0;
    end else if (bus.vsync_pulse) begin
      r_acc        <= '0;
      r_coll       <= r_acc | w_contrib;
      r_coll_valid <= 1'b1;
    end else begin
      r_acc        <= r_acc | w_contrib;
      r_coll_valid <= 1'b0;
    end
  end

  assign bus.cfg_ready       = !bus.vsync_pulse;
  assign bus.is_ball         = r_is_ball;
  assign bus.DrawX_o         = r_x_o;
  assign bus.DrawY_o         = r_y_o;
  assign bus.collision       = r_coll;
  assign bus.collision_valid = r_coll_valid;

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Directed bench for pixel_layer_arbiter: vector table through the pipeline plus
// hand-written sequences for commit timing, stalls, config handshake and reset.
module tb_pixel_layer_arbiter;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_err;

  pixel_layer_arbiter_if bus ();

  pixel_layer_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] ball;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [4:0] ball, input logic [9:0] x,
                         input logic [9:0] y);
    chk({name, ".is_ball"}, 32'(bus.is_ball), 32'(ball));
    chk({name, ".DrawX_o"}, 32'(bus.DrawX_o), 32'(x));
    chk({name, ".DrawY_o"}, 32'(bus.DrawY_o), 32'(y));
  endtask

  task automatic pixel(input logic [3:0] hit, input logic [9:0] x, input logic [9:0] y);
    bus.obj_hit  = hit;
    bus.DrawX    = x;
    bus.DrawY    = y;
    bus.pixel_en = 1'b1;
    tick();
    bus.pixel_en = 1'b0;
  endtask

  task automatic vsync();
    bus.vsync_pulse = 1'b1;
    tick();
    bus.vsync_pulse = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [4:0] code, input logic en);
    bus.cfg_valid = 1'b1;
    bus.cfg_idx   = idx;
    bus.cfg_code  = code;
    bus.cfg_en    = en;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic chk_frame(input string name, input logic [3:0] exp_coll);
    chk({name, ".valid"}, 32'(bus.collision_valid), 32'd1);
    chk({name, ".collision"}, 32'(bus.collision), 32'(exp_coll));
    tick();
    chk({name, ".valid_drop"}, 32'(bus.collision_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_c;
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{hit: 4'b0000, x: 10'd1,  y: 10'd1,  ball: 5'd0};
    vecs[1] = '{hit: 4'b0110, x: 10'd2,  y: 10'd3,  ball: 5'd2};
    vecs[2] = '{hit: 4'b0001, x: 10'd3,  y: 10'd4,  ball: 5'd1};
    vecs[3] = '{hit: 4'b1000, x: 10'd5,  y: 10'd6,  ball: 5'd4};
    vecs[4] = '{hit: 4'b1100, x: 10'd7,  y: 10'd8,  ball: 5'd3};
    vecs[5] = '{hit: 4'b1111, x: 10'd9,  y: 10'd10, ball: 5'd1};
    vecs[6] = '{hit: 4'b0000, x: 10'd11, y: 10'd12, ball: 5'd0};

    Reset           = 1'b1;
    bus.pixel_en    = 1'b0;
    bus.vsync_pulse = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.obj_hit     = '0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_idx     = '0;
    bus.cfg_code    = '0;
    bus.cfg_en      = 1'b0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state and idle pixels
    chk_out("reset", 5'd0, 10'd0, 10'd0);
    chk("reset.collision", 32'(bus.collision), 32'd0);
    chk("reset.valid", 32'(bus.collision_valid), 32'd0);
    chk("reset.cfg_ready", 32'(bus.cfg_ready), 32'd1);
    for (int i = 0; i < 3; i++) pixel(4'b0000, 10'(i), 10'(i));
    chk("idle.is_ball", 32'(bus.is_ball), 32'd0);
    chk("idle.collision", 32'(bus.collision), 32'd0);

    // Two-object overlap: lower index wins, collision reported at vsync
    pixel(4'b0110, 10'd100, 10'd50);
    chk("lat1.is_ball", 32'(bus.is_ball), 32'd0);
    pixel(4'b0000, 10'd101, 10'd50);
    chk_out("overlap", 5'd2, 10'd100, 10'd50);
    vsync();
    chk_frame("frame_overlap", 4'b0110);

    // Vector table with default codes
    exp_c = '0;
    for (int i = 0; i < 7; i++) begin
      pixel(vecs[i].hit, vecs[i].x, vecs[i].y);
      if (i > 0) chk_out($sformatf("vec%0d", i - 1), vecs[i-1].ball, vecs[i-1].x, vecs[i-1].y);
      if ($countones(vecs[i].hit) >= 2) exp_c = exp_c | vecs[i].hit;
    end
    pixel(4'b0000, 10'd0, 10'd0);
    chk_out("vec6", vecs[6].ball, vecs[6].x, vecs[6].y);
    vsync();
    chk_frame("frame_table", exp_c);

    // Mid-frame write is shadowed until commit; empty frame still pulses valid
    cfg_write(2'd2, 5'd4, 1'b1);
    pixel(4'b0100, 10'd30, 10'd31);
    pixel(4'b0000, 10'd0, 10'd0);
    chk("precommit.is_ball", 32'(bus.is_ball), 32'd3);
    vsync();
    chk_frame("frame_empty", 4'b0000);
    pixel(4'b0100, 10'd30, 10'd31);
    pixel(4'b0000, 10'd0, 10'd0);
    chk("postcommit.is_ball", 32'(bus.is_ball), 32'd4);

    // Disabled object ignored for drawing and collision
    cfg_write(2'd0, 5'd1, 1'b0);
    vsync();
    tick();
    pixel(4'b0011, 10'd40, 10'd41);
    pixel(4'b0000, 10'd0, 10'd0);
    chk("disabled.is_ball", 32'(bus.is_ball), 32'd2);
    vsync();
    chk_frame("frame_disabled", 4'b0000);

    // Enabled code-0 object wins priority and draws background
    cfg_write(2'd1, 5'd0, 1'b1);
    vsync();
    tick();
    pixel(4'b0110, 10'd42, 10'd43);
    pixel(4'b0000, 10'd0, 10'd0);
    chk("code0.is_ball", 32'(bus.is_ball), 32'd0);
    vsync();
    chk_frame("frame_code0", 4'b0110);

    // pixel_en low holds every pipeline register
    pixel(4'b1000, 10'd20, 10'd21);
    pixel(4'b0000, 10'd22, 10'd23);
    chk_out("stall_pre", 5'd4, 10'd20, 10'd21);
    for (int i = 0; i < 5; i++) begin
      bus.obj_hit = 4'b0100;
      bus.DrawX   = 10'(500 + i);
      bus.DrawY   = 10'(600 + i);
      tick();
      chk_out($sformatf("stall%0d", i), 5'd4, 10'd20, 10'd21);
    end
    pixel(4'b0100, 10'd24, 10'd25);
    chk_out("stall_post", 5'd0, 10'd22, 10'd23);
    pixel(4'b0000, 10'd0, 10'd0);

    // Config held across vsync: blocked in the commit cycle, taken the next one
    bus.vsync_pulse = 1'b1;
    bus.cfg_valid   = 1'b1;
    bus.cfg_idx     = 2'd3;
    bus.cfg_code    = 5'd9;
    bus.cfg_en      = 1'b1;
    #1;
    chk("vsync.cfg_ready", 32'(bus.cfg_ready), 32'd0);
    tick();
    bus.vsync_pulse = 1'b0;
    #1;
    chk("after_vsync.cfg_ready", 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
    pixel(4'b1000, 10'd60, 10'd61);
    pixel(4'b0000, 10'd0, 10'd0);
    chk("late_write_shadow.is_ball", 32'(bus.is_ball), 32'd4);
    vsync();
    pixel(4'b1000, 10'd62, 10'd63);
    pixel(4'b0000, 10'd0, 10'd0);
    chk("late_write_commit.is_ball", 32'(bus.is_ball), 32'd9);
    vsync();
    tick();

    // Reset mid-frame drops accumulator, tables and pending shadow writes
    pixel(4'b1100, 10'd70, 10'd71);
    pixel(4'b0000, 10'd0, 10'd0);
    cfg_write(2'd3, 5'd7, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_out("midreset", 5'd0, 10'd0, 10'd0);
    vsync();
    chk_frame("frame_after_reset", 4'b0000);
    pixel(4'b0001, 10'd80, 10'd81);
    pixel(4'b1000, 10'd82, 10'd83);
    chk_out("reset_tbl0", 5'd1, 10'd80, 10'd81);
    pixel(4'b0000, 10'd0, 10'd0);
    chk_out("reset_tbl3", 5'd4, 10'd82, 10'd83);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
